// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  function automatic logic [NumReq-1:0] idx_to_onehot(input logic [IdxW-1:0] idx);
    return NumReq'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Round-robin winner select: rotated 8-to-3 priority encoder starting at ptr.
module rr_pick_8
  import rr_arbiter_8_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   winner,
  output logic              valid
);

  logic [NumReq-1:0] rot;
  logic [IdxW-1:0]   off;

  // rot[i] is requester (ptr + i) mod 8, so the lowest set bit is the winner
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rot[i] = req[IdxW'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot[i]) off = IdxW'(i);
    end
  end

  assign winner = off + ptr;
  assign valid  = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with done/drop release and a MAX_HOLD forced release.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  input  logic              done,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_id,
  output logic              busy,
  output logic              idle,
  output logic              timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   id_q, id_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [7:0]        hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic [IdxW-1:0] winner;
  logic            any_req;
  logic            rel_done, rel_drop, rel_hold, release_now;

  rr_pick_8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (any_req)
  );

  assign rel_done    = done;
  assign rel_drop    = ~req[id_q];
  assign rel_hold    = (hold_q == HoldLast);
  assign release_now = rel_done | rel_drop | rel_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (any_req) state_d = StBusy;
      StBusy: if (release_now) state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          id_d    = winner;
          grant_d = idx_to_onehot(winner);
          busy_d  = 1'b1;
          hold_d  = '0;
          ptr_d   = winner + IdxW'(1);
        end else begin
          id_d    = '0;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      StBusy: begin
        if (release_now) begin
          id_d      = '0;
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          // done wins over a coincident hold expiry, so no timeout then
          timeout_d = rel_hold & ~rel_done;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      id_q      <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign idle     = ~|req;

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum cycles a grant is held before forced release; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  request vector; req[k] high = requester k wants the resource.
REQ-005 Port: done  input  1  current holder finished; sampled only in BUSY.
REQ-006 Port: grant  output  8  registered one-hot grant; all-zero when no grant.
REQ-007 Port: grant_id  output  3  registered binary index of granted requester; 0 when no grant.
REQ-008 Port: busy  output  1  registered, high while a grant is held.
REQ-009 Port: idle  output  1  combinational, high when req == 8'b0.
REQ-010 Port: timeout  output  1  registered one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 FSM states SHALL be IDLE and BUSY only.
REQ-012 In IDLE with req != 0, the block SHALL select a winner at the rising edge, enter BUSY, and present grant/grant_id/busy after that edge (1-cycle latency from req to grant).
REQ-013 In IDLE with req == 0, the FSM SHALL remain in IDLE with grant = 0, busy = 0.
REQ-014 Winner selection SHALL be round-robin: scan indices ptr, ptr+1, ... 7, 0, ... ptr-1 (mod 8) and pick the first k with req[k] = 1.
REQ-015 The pointer ptr SHALL update to (winner + 1) mod 8 when the grant is issued; winner 7 wraps ptr to 0.
REQ-016 In BUSY, grant SHALL stay constant while none of the following occurs: done = 1, req[grant_id] = 0, or hold count reaching MAX_HOLD.
REQ-017 On any release condition, the FSM SHALL return to IDLE at the next edge, clearing grant, grant_id and busy.
REQ-018 At least one cycle with grant = 0 SHALL separate consecutive grants (no back-to-back grants).
REQ-019 The hold counter SHALL clear on entering BUSY, increment once per BUSY cycle, and trigger release when its value equals MAX_HOLD - 1 at an edge (grant held exactly MAX_HOLD cycles).
REQ-020 timeout SHALL pulse high for one cycle, coincident with the grant = 0 cycle, only when the counter caused the release.
REQ-021 If done and the timeout condition occur together, release SHALL be by done and timeout SHALL stay 0.
REQ-022 Requests from other requesters during BUSY SHALL be ignored; they cannot preempt the holder.
REQ-023 grant SHALL always be zero or exactly one-hot, and equal to 1 << grant_id when busy = 1.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, grant = 0, grant_id = 0, busy = 0, timeout = 0, hold counter = 0, ptr = 0.
REQ-025 Reset asserted mid-grant SHALL drop the grant asynchronously; after release, the first arbitration starts from ptr = 0.

Structure
REQ-026 A shared package SHALL hold the FSM state type, the requester count constant (8) and the index width constant (3).
REQ-027 Winner selection SHALL be one combinational sub-module, rr_pick_8 (inputs req, ptr; outputs winner index, any-valid), implemented as a rotated 8-to-3 priority encoder.

Verification
REQ-028 Reset, then req = 8'b0011_0000 -> one cycle later grant = 8'b0001_0000, grant_id = 4, busy = 1; ptr becomes 5.
REQ-029 Hold req = 8'b1111_1111 and pulse done each time busy = 1 -> grant_id sequence 0,1,...,7,0 with one zero-grant cycle between each.
REQ-030 MAX_HOLD = 4, req = 8'b0000_0100 held, done = 0 -> grant = 8'b0000_0100 for exactly 4 cycles, then grant = 0 with timeout = 1 for one cycle, then regrant of index 2.
REQ-031 While grant_id = 3, raise req = 8'b1000_1000 then drop req[3] -> grant clears next edge; next grant is index 7.
REQ-032 Assert rst_n = 0 mid-grant with req = 8'b1010_0000 -> grant = 0 immediately; after release, first grant is index 5.
REQ-033 req = 8'b0000_0000 -> idle = 1, grant = 0, busy = 0 for all cycles.
